// File: rtl/huffman_pkg.sv
// huffman_pkg: shared FSM states and code constants for the Huffman xmem loader
package huffman_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PREFIX  = 2'd1;
    localparam state_t ST_LITERAL = 2'd2;
    localparam state_t ST_WRITE   = 2'd3;
    localparam int SYM_ZERO = 0;
    localparam int SYM_ONE  = 1;
    localparam int ESC_LEN  = 3;
endpackage

// File: rtl/huffman_symbol_decoder.sv
// huffman_symbol_decoder: serial prefix/literal decoder emitting one-cycle sym_valid/sym pulses
// Ports: clk/reset; active enables bit acceptance; in_literal selects literal shifting;
//        bit_in/bit_valid/bit_ready form the bit handshake; escape pulses on a '111' prefix.
module huffman_symbol_decoder
    import huffman_pkg::*;
#(
    parameter int bw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          in_literal,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          bit_ready,
    output logic          sym_valid,
    output logic          escape,
    output logic [bw-1:0] sym
);
    localparam int CW = bw > 1 ? $clog2(bw) : 1;
    logic [1:0]    depth_q, depth_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [bw-1:0] lit_q, lit_d, shifted;
    logic          take;
    assign bit_ready = active;
    always_comb begin
        take      = bit_valid & active;
        shifted   = {lit_q[bw-2:0], bit_in};
        sym_valid = take & (in_literal ? cnt_q == CW'(bw - 1) : ~bit_in);
        escape    = take & ~in_literal & bit_in & (depth_q == 2'(ESC_LEN - 1));
        sym       = in_literal ? shifted : depth_q == 2'd0 ? bw'(SYM_ZERO) : depth_q == 2'd1 ? bw'(SYM_ONE) : '1;
        depth_d   = (~take | in_literal) ? depth_q : (~bit_in | escape) ? 2'd0 : depth_q + 2'd1;
        cnt_d     = (take & in_literal) ? (sym_valid ? '0 : cnt_q + CW'(1)) : cnt_q;
        lit_d     = (take & in_literal) ? shifted : lit_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            cnt_q   <= '0;
            lit_q   <= '0;
        end else begin
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            lit_q   <= lit_d;
        end
    end
endmodule

// File: rtl/huffman_xmem_loader.sv
// huffman_xmem_loader: decodes a serial Huffman stream, packs col symbols per word, writes them to xmem
// Ports: start/base_addr/num_words launch a job; bit_in/bit_valid/bit_ready carry code bits;
//        mem_ready grants xmem; mem_cen/mem_wen/mem_addr/mem_d drive the SRAM; busy/done report status.
// Optional: HUFF_STATS_EN adds sym_count and literal_count.
module huffman_xmem_loader
    import huffman_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_bw-1:0]  base_addr,
    input  logic [cnt_bw-1:0]   num_words,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    input  logic                mem_ready,
    output logic                mem_cen,
    output logic                mem_wen,
    output logic [addr_bw-1:0]  mem_addr,
    output logic [col*bw-1:0]   mem_d,
    output logic                busy,
    output logic                done
`ifdef HUFF_STATS_EN
    ,
    output logic [cnt_bw-1:0]   sym_count,
    output logic [cnt_bw-1:0]   literal_count
`endif
);
    localparam int LW = col > 1 ? $clog2(col) : 1;
    localparam int SW = addr_bw > cnt_bw ? addr_bw : cnt_bw;
    state_t              state_q, state_d;
    logic [addr_bw-1:0]  base_q, base_d, addr_q, addr_d;
    logic [cnt_bw-1:0]   num_q, num_d, idx_q, idx_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [col*bw-1:0]   word_q, word_d, data_q, data_d, packed_w;
    logic                done_q, done_d;
    logic [SW-1:0]       addr_sum;
    logic [bw-1:0]       sym;
    logic                sym_valid, escape, decoding, pending, last_lane, last_word;
    assign decoding = state_q == ST_PREFIX || state_q == ST_LITERAL;
    assign pending  = state_q == ST_WRITE;
    huffman_symbol_decoder #(.bw(bw)) u_dec (
        .clk        (clk),
        .reset      (reset),
        .active     (decoding),
        .in_literal (state_q == ST_LITERAL),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .escape     (escape),
        .sym        (sym)
    );
    always_comb begin
        last_lane = lane_q == LW'(col - 1);
        last_word = idx_q + cnt_bw'(1) == num_q;
        packed_w  = word_q;
        packed_w[lane_q*bw +: bw] = sym;
        addr_sum  = SW'(base_q) + SW'(idx_q);
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        word_d    = word_q;
        data_d    = data_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        if (state_q == ST_IDLE && start) begin
            base_d  = base_addr;
            num_d   = num_words;
            idx_d   = '0;
            lane_d  = '0;
            done_d  = num_words == '0;
            state_d = num_words == '0 ? ST_IDLE : ST_PREFIX;
        end
        if (decoding) begin
            state_d = (sym_valid & last_lane) ? ST_WRITE : escape ? ST_LITERAL : sym_valid ? ST_PREFIX : state_q;
            word_d  = sym_valid ? packed_w : word_q;
            lane_d  = sym_valid ? (last_lane ? '0 : lane_q + LW'(1)) : lane_q;
            data_d  = (sym_valid & last_lane) ? packed_w : data_q;
            addr_d  = (sym_valid & last_lane) ? addr_sum[addr_bw-1:0] : addr_q;
        end
        if (pending & mem_ready) begin
            idx_d   = idx_q + cnt_bw'(1);
            done_d  = last_word;
            state_d = last_word ? ST_IDLE : ST_PREFIX;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end
    assign mem_cen  = ~(pending & mem_ready);
    assign mem_wen  = ~(pending & mem_ready);
    assign mem_addr = addr_q;
    assign mem_d    = data_q;
    assign busy     = state_q != ST_IDLE;
    assign done     = done_q;
`ifdef HUFF_STATS_EN
    logic [cnt_bw-1:0] sym_cnt_q, sym_cnt_d, lit_cnt_q, lit_cnt_d;
    always_comb begin
        sym_cnt_d = (state_q == ST_IDLE && start) ? '0 : (sym_valid & ~&sym_cnt_q) ? sym_cnt_q + cnt_bw'(1) : sym_cnt_q;
        lit_cnt_d = (state_q == ST_IDLE && start) ? '0 : (escape & ~&lit_cnt_q) ? lit_cnt_q + cnt_bw'(1) : lit_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt_q <= '0;
            lit_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            lit_cnt_q <= lit_cnt_d;
        end
    end
    assign sym_count     = sym_cnt_q;
    assign literal_count = lit_cnt_q;
`endif
endmodule
